// File: rtl/cpu_phase_controller.sv
// Eight-phase instruction sequencer: phase counter, sticky halt and per-phase
// strobe decode for the PC, memory, IR, accumulator and data-bus drivers.
module cpu_phase_controller #(
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic [2:0]      phase,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            ld_ac,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            data_e,
  output logic            halt
);

  localparam logic [OP_W-1:0] OP_HLT = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_STO = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP = 3'b111;

  logic [2:0] phase_q, phase_d;
  logic       halt_q, halt_d;
  logic       run;
  logic       aluop, is_sto, is_jmp, is_skz;
  logic       sel_d, rd_d, wr_d, ld_ir_d, ld_ac_d, inc_pc_d, ld_pc_d, data_e_d;

  assign run    = enable & ~halt_q;
  assign aluop  = (opcode == OP_ADD) | (opcode == OP_AND) |
                  (opcode == OP_XOR) | (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_skz = (opcode == OP_SKZ);

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 3'd0;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  // Halt latches on the 4->5 step, so a halted core parks in phase 5.
  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    if (run) begin
      phase_d = phase_q + 3'd1;
      if ((phase_q == 3'd4) && (opcode == OP_HLT))
        halt_d = 1'b1;
    end
  end

  always_comb begin
    sel_d    = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ld_ir_d  = 1'b0;
    ld_ac_d  = 1'b0;
    inc_pc_d = 1'b0;
    ld_pc_d  = 1'b0;
    data_e_d = 1'b0;
    case (phase_q)
      3'd0: sel_d = 1'b1;
      3'd1: begin sel_d = 1'b1; rd_d = 1'b1; end
      3'd2: begin sel_d = 1'b1; rd_d = 1'b1; ld_ir_d = 1'b1; end
      3'd3: begin sel_d = 1'b1; rd_d = 1'b1; ld_ir_d = 1'b1; end
      3'd4: inc_pc_d = 1'b1;
      3'd5: rd_d = aluop;
      3'd6: begin
        rd_d     = aluop;
        inc_pc_d = is_skz & zero;
        ld_pc_d  = is_jmp;
        data_e_d = is_sto;
      end
      default: begin
        rd_d     = aluop;
        ld_ac_d  = aluop;
        ld_pc_d  = is_jmp;
        wr_d     = is_sto;
        data_e_d = is_sto;
      end
    endcase
  end

  // sel tracks the decode regardless of run; every strobe is gated by it.
  assign phase  = phase_q;
  assign halt   = halt_q;
  assign sel    = sel_d;
  assign rd     = rd_d     & run;
  assign wr     = wr_d     & run;
  assign ld_ir  = ld_ir_d  & run;
  assign ld_ac  = ld_ac_d  & run;
  assign inc_pc = inc_pc_d & run;
  assign ld_pc  = ld_pc_d  & run;
  assign data_e = data_e_d & run;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Scoreboard bench for cpu_phase_controller: a reference model pushes the
// expected output vector each cycle; the negedge sample pops and compares it.
module tb_cpu_phase_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic [2:0] phase;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011,
                         XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  cpu_phase_controller #(.OP_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode), .zero(zero),
    .phase(phase), .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .halt(halt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [2:0]  m_phase = 3'd0;
  logic        m_halt = 1'b0;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output vector: {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}
  function automatic logic [11:0] model_out(input logic [2:0] ph, input logic hl,
                                            input logic en, input logic [2:0] op,
                                            input logic z);
    logic s, r, w, ir, ac, ip, lp, de, alu, act;
    alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    act = en && !hl;
    s = (ph <= 3'd3);
    r = 0; w = 0; ir = 0; ac = 0; ip = 0; lp = 0; de = 0;
    if (ph == 3'd1 || ph == 3'd2 || ph == 3'd3) r = 1;
    if (ph >= 3'd5) r = alu;
    if (ph == 3'd2 || ph == 3'd3) ir = 1;
    if (ph == 3'd4) ip = 1;
    if (ph == 3'd6) ip = (op == SKZ) && z;
    if (ph >= 3'd6) begin lp = (op == JMP); de = (op == STO); end
    if (ph == 3'd7) begin ac = alu; w = (op == STO); end
    if (!act) begin r = 0; w = 0; ir = 0; ac = 0; ip = 0; lp = 0; de = 0; end
    return {ph, s, r, w, ir, ac, ip, lp, de, hl};
  endfunction

  // One clock: drive inputs, push expectation, compare at negedge, advance model.
  task automatic cyc(input logic rst, input logic en, input logic [2:0] op, input logic z,
                     input string tag);
    logic [11:0] e;
    reset = rst; enable = en; opcode = op; zero = z;
    exp_q.push_back(model_out(m_phase, m_halt, en, op, z));
    @(negedge clock);
    e = exp_q.pop_front();
    check_val(tag, {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}, e);
    if (rd && wr) check_val("inv_rd_wr", 12'd1, 12'd0);
    if (inc_pc && ld_pc) check_val("inv_inc_ld", 12'd1, 12'd0);
    if (rst) begin
      m_phase = 3'd0; m_halt = 1'b0;
    end else if (en && !m_halt) begin
      if (m_phase == 3'd4 && op == HLT) m_halt = 1'b1;
      m_phase = m_phase + 3'd1;
    end
    @(posedge clock); #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, op, z, tag);
  endtask

  initial begin
    // Unchecked first reset edge brings the DUT out of X.
    @(posedge clock); #1;
    cyc(1'b1, 1'b1, LDA, 1'b0, "reset");
    run_instr(LDA, 1'b0, "lda");
    run_instr(STO, 1'b0, "sto");
    run_instr(SKZ, 1'b1, "skz_z1");
    run_instr(SKZ, 1'b0, "skz_z0");
    run_instr(JMP, 1'b0, "jmp");
    run_instr(ADD, 1'b1, "add_z1");
    run_instr(AND_, 1'b0, "and");
    run_instr(XOR_, 1'b1, "xor");
    // Enable drop in phase 2 for three cycles, then resume.
    cyc(1'b0, 1'b1, LDA, 1'b0, "en_p0");
    cyc(1'b0, 1'b1, LDA, 1'b0, "en_p1");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, LDA, 1'b0, "en_hold");
    check_val("hold_phase", {9'd0, phase}, 12'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, LDA, 1'b0, "en_resume");
    // Now in phase 6: reset here restarts at 0.
    check_val("pre_rst_phase", {9'd0, phase}, 12'd6);
    cyc(1'b1, 1'b1, LDA, 1'b0, "rst_p6");
    check_val("post_rst_phase", {9'd0, phase}, 12'd0);
    // HLT at phase 4 with enable low must not halt.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, HLT, 1'b0, "hlt_fetch");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, HLT, 1'b0, "hlt_en0");
    check_val("no_halt", {10'd0, halt, 1'b0}, 12'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, HLT, 1'b1, "halted");
    check_val("halt_phase", {8'd0, halt, phase}, 12'h00D);
    cyc(1'b1, 1'b1, HLT, 1'b0, "halt_rst");
    check_val("halt_clear", {8'd0, halt, phase}, 12'h000);
    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
    if (exp_q.size() != 0) check_val("sb_empty", 12'(exp_q.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
- Eight-phase instruction sequencer for the 8-bit RISC CPU.
- Drives the program counter (increment, load, skip), memory read/write strobes, instruction-register and accumulator load enables, the address mux select and the data-bus output enable.
- Sits between the instruction register opcode and the datapath. Owns the only cycle-level state machine in the core.

Parameters:
- OP_W, 3, opcode width. Only 3 is supported; the opcode map below is fixed.

Ports:
- clock   input   1  system clock, all state on rising edge
- reset   input   1  synchronous, active-high; forces phase 0 and clears halt
- enable  input   1  CPU run enable; low freezes the phase counter
- opcode  input   3  current instruction register opcode
- zero    input   1  accumulator-zero flag from the ALU
- phase   output  3  current phase, 0..7
- sel     output  1  address mux: 1 = program counter, 0 = instruction operand address
- rd      output  1  memory read strobe
- wr      output  1  memory write strobe
- ld_ir   output  1  instruction register load
- ld_ac   output  1  accumulator load
- inc_pc  output  1  program counter increment (maps to the counter's enable/increment input)
- ld_pc   output  1  program counter load from operand address (jump)
- data_e  output  1  accumulator-to-data-bus output enable
- halt    output  1  sticky halt indication

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP means ADD, AND, XOR or LDA.

State and reset:
- State is a 3-bit phase register plus a halt flag.
- Reset (synchronous, clock edge with reset=1): phase<=0, halt<=0.
- Reset has priority over enable and halt, and is legal in any phase; the next instruction restarts at phase 0.

Phase advance:
- Phase advances by 1 each clock when enable=1 and halt=0.
- Wraps from 7 to 0.
- With enable=0 or halt=1 the phase holds.

Halt:
- halt is set on the clock edge leaving phase 4 when opcode=HLT and enable=1.
- Once set, phase stays at 5 until reset.
- halt stays 1 until reset.

Output decode:
- Strobe outputs are combinational from the phase register and opcode; there is no additional latency.
- While enable=0 or halt=1, all strobes (rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e) are forced 0. sel still follows the decode.
- Any strobe not listed for a phase is 0.
- Phase 0: sel=1.
- Phase 1: sel=1, rd=1.
- Phase 2: sel=1, rd=1, ld_ir=1.
- Phase 3: sel=1, rd=1, ld_ir=1.
- Phase 4: sel=0, inc_pc=1.
- Phase 5: sel=0, rd=ALUOP.
- Phase 6: sel=0, rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
- Phase 7: sel=0, rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.

Reset values (all outputs):
- phase=0, sel=1, halt=0, all strobes 0.

Invariants:
- wr and rd are never both 1.
- inc_pc and ld_pc are never both 1.
- ld_ir only in phases 2 and 3.

Boundary conditions:
- opcode changes mid-instruction: decode uses the current opcode each cycle. The IR is only loaded in phases 2–3, so opcode is stable over phases 4–7.
- zero is sampled combinationally in phase 6 only; zero=1 with a non-SKZ opcode has no effect.
- enable dropping mid-instruction: strobes go to 0 that cycle. The phase resumes where it stopped once enable returns.
- HLT decoded while enable=0: halt is not set, because the phase is not advancing.

Test Plan:
1. Reset then run: reset=1 one cycle, enable=1, opcode=LDA -> phase steps 0,1,...,7,0. rd=1 in phases 1,2,3,5,6,7. ld_ir=1 in phases 2–3. inc_pc=1 in phase 4 only. ld_ac=1 in phase 7 only. wr=0 throughout.
2. STO: opcode=110 -> rd=0 in phases 5–7. data_e=1 in phases 6–7. wr=1 in phase 7 only. ld_ac=0.
3. SKZ: opcode=001 with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc=1 in phase 4 only.
4. JMP: opcode=111 -> ld_pc=1 in phases 6 and 7. inc_pc=0 in phase 6.
5. HLT: opcode=000 -> halt=1 after the phase-4 edge and phase stays at 5 for 10+ cycles with all strobes 0. A reset pulse then gives phase=0, halt=0.
6. Enable/reset mid-op: enable=0 in phase 2 for 3 cycles -> phase stays 2 and ld_ir=0; re-enable resumes at phase 2→3. A reset asserted in phase 6 gives phase=0 on the next edge.
